// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
//
// Converts a 13-bit binary value into four BCD digits with a sequential
// shift-add-3 (double-dabble) engine, then time-multiplexes those digits onto
// a 4-digit common-anode seven-segment display.
//
// Parameters:
//   REFRESH_BITS : width of the free-running scan counter (>= 2). The top two
//                  bits select the digit, so each digit is held for
//                  2^(REFRESH_BITS-2) cycles.
//   BLANK_LZ     : 1 = blank leading zeros in thousands/hundreds/tens.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   num       in   [12:0] binary value to display (0..8191)
//   anode     out  [3:0]  digit enables, active-low, bit0 = units
//   cathode   out  [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   bcd       out  [15:0] displayed digits {thousands,hundreds,tens,units}
//   busy      out  high while a conversion is in progress
//   bcd_valid out  one-cycle pulse when bcd is updated
// ---------------------------------------------------------------------------
module ssd_scan_driver #(
  parameter int REFRESH_BITS = 18,
  parameter bit BLANK_LZ     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] num,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        bcd_valid
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [REFRESH_BITS-1:0] SCAN_ONE = 1;

  state_t      state, state_nxt;
  logic [12:0] last_num, last_num_nxt;
  logic [12:0] shreg, shreg_nxt;
  logic [15:0] acc, acc_nxt, acc_adj;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] bcd_nxt;
  logic        busy_nxt, bcd_valid_nxt;

  logic [REFRESH_BITS-1:0] scan_cnt;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic                    digit_blank;
  logic [3:0]              anode_nxt;
  logic [6:0]              cathode_nxt;

  // ---------------------------------------------------------------------------
  // Conversion engine
  // ---------------------------------------------------------------------------

  // Add-3 correction: any nibble that would reach 10 or more after the next
  // doubling is pre-biased so the shift carries correctly into the next digit.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3
                                                   : acc[4*i +: 4];
    end
  end

  // NOTE: every signal is given a default before the case statement so each
  // path assigns it and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    last_num_nxt  = last_num;
    shreg_nxt     = shreg;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    bcd_nxt       = bcd;
    busy_nxt      = busy;
    bcd_valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        // num is only looked at here; a change during a conversion is
        // picked up on the first IDLE cycle afterwards.
        if (num != last_num) begin
          shreg_nxt    = num;
          last_num_nxt = num;
          acc_nxt      = '0;
          cnt_nxt      = '0;
          busy_nxt     = 1'b1;
          state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        {acc_nxt, shreg_nxt} = {acc_adj, shreg} << 1;
        cnt_nxt              = cnt + 4'd1;
        // cnt counts completed shifts; 12 here means this is the 13th.
        if (cnt == 4'd12) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bcd_nxt       = acc;
        bcd_valid_nxt = 1'b1;
        busy_nxt      = 1'b0;
        state_nxt     = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_num  <= '0;
      shreg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd       <= '0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_num  <= last_num_nxt;
      shreg     <= shreg_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      bcd       <= bcd_nxt;
      busy      <= busy_nxt;
      bcd_valid <= bcd_valid_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign sel = scan_cnt[REFRESH_BITS-1 -: 2];

  // A slot is blanked when its digit and every more-significant digit are
  // zero; the units slot is always shown.
  always_comb begin
    digit       = bcd[3:0];
    digit_blank = 1'b0;
    case (sel)
      2'd0: begin
        digit = bcd[3:0];
      end
      2'd1: begin
        digit       = bcd[7:4];
        digit_blank = (bcd[15:4] == 12'd0);
      end
      2'd2: begin
        digit       = bcd[11:8];
        digit_blank = (bcd[15:8] == 8'd0);
      end
      default: begin
        digit       = bcd[15:12];
        digit_blank = (bcd[15:12] == 4'd0);
      end
    endcase

    if (BLANK_LZ && digit_blank) begin
      anode_nxt   = 4'b1111;
      cathode_nxt = 7'b1111111;
    end else begin
      anode_nxt   = ~(4'b0001 << sel);
      cathode_nxt = seg7(digit);
    end
  end

  // Pins are registered so they stay glitch-free across digit changes and
  // the scan counter wrap; they lag sel and bcd by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      anode    <= 4'b1111;
      cathode  <= 7'b1111111;
    end else begin
      scan_cnt <= scan_cnt + SCAN_ONE;
      anode    <= anode_nxt;
      cathode  <= cathode_nxt;
    end
  end

endmodule
